// File: rtl/dap_ctrl_pkg.sv
// Shared encodings for the double-accumulator processor control unit:
// state codes, opcodes, datapath mux selects and the control-word layout.
package dap_ctrl_pkg;

  typedef logic [3:0] state_t;
  typedef logic [3:0] opc_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_EXEC   = 4'd3;
  localparam state_t S_BRANCH = 4'd4;
  localparam state_t S_MEM    = 4'd5;
  localparam state_t S_WB     = 4'd6;
  localparam state_t S_HALTED = 4'd7;
  localparam state_t S_ERROR  = 4'd8;

  localparam opc_t OP_ADD  = 4'd0;
  localparam opc_t OP_SUB  = 4'd1;
  localparam opc_t OP_ADDI = 4'd2;
  localparam opc_t OP_LW   = 4'd3;
  localparam opc_t OP_SW   = 4'd4;
  localparam opc_t OP_BEQ  = 4'd5;
  localparam opc_t OP_JMP  = 4'd6;
  localparam opc_t OP_HALT = 4'd15;

  localparam logic [1:0] PC_SRC_ALU  = 2'd0;
  localparam logic [1:0] PC_SRC_JUMP = 2'd1;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_ACC1 = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_ACC2 = 2'd0;
  localparam logic [1:0] SRC_B_ONE  = 2'd1;
  localparam logic [1:0] SRC_B_IMM1 = 2'd2;
  localparam logic [1:0] SRC_B_IMM2 = 2'd3;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // One bundle for every datapath enable and select driven by the FSM.
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_write;
    logic       alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       acc_write;
    logic       acc_src;
    logic       halted;
    logic       error;
  } ctrl_t;

  function automatic logic is_legal(input opc_t opc);
    return (opc <= OP_JMP) || (opc == OP_HALT);
  endfunction

  function automatic logic is_alu_class(input opc_t opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_ADDI);
  endfunction

  function automatic logic is_mem_class(input opc_t opc);
    return (opc == OP_LW) || (opc == OP_SW);
  endfunction

endpackage

// File: rtl/dap_mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready and flags when the
// wait has reached TIMEOUT; cleared whenever the controller changes state.
module dap_mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/dap_control_unit.sv
// Multicycle control FSM for the double-accumulator processor: sequences
// fetch/decode/execute/memory/write-back with a timed memory handshake.
module dap_control_unit #(
  parameter int OPC_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_write,
  output logic             alu_op,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             acc_write,
  output logic             acc_src,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  import dap_ctrl_pkg::*;

  state_t state;
  state_t state_next;
  opc_t   opc;
  ctrl_t  ctrl;
  logic   waiting;
  logic   timed_out;
  logic   retire_now;

  assign opc     = opc_t'(opcode);
  assign waiting = (state == S_FETCH) || (state == S_MEM);

  dap_mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .clear    (state_next != state),
    .count_en (waiting && !mem_ready),
    .expired  (timed_out)
  );

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready)      state_next = S_DECODE;
        else if (timed_out) state_next = S_ERROR;
      end
      S_DECODE: begin
        if (opc == OP_HALT)     state_next = S_HALTED;
        else if (!is_legal(opc)) state_next = S_ERROR;
        else                     state_next = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu_class(opc))      state_next = S_WB;
        else if (is_mem_class(opc)) state_next = S_MEM;
        else if (opc == OP_BEQ)     state_next = alu_zero ? S_BRANCH : S_FETCH;
        else if (opc == OP_JMP)     state_next = S_FETCH;
        else                        state_next = S_ERROR;
      end
      S_BRANCH: state_next = S_FETCH;
      S_MEM: begin
        if (mem_ready)      state_next = (opc == OP_LW) ? S_WB : S_FETCH;
        else if (timed_out) state_next = S_ERROR;
      end
      S_WB:     state_next = S_FETCH;
      S_HALTED: state_next = S_HALTED;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_ERROR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_next;
  end

  // An instruction retires on the edge that leaves its last state.
  always_comb begin
    retire_now = 1'b0;
    case (state)
      S_EXEC:   retire_now = ((opc == OP_BEQ) && !alu_zero) || (opc == OP_JMP);
      S_BRANCH: retire_now = 1'b1;
      S_MEM:    retire_now = mem_ready && (opc == OP_SW);
      S_WB:     retire_now = 1'b1;
      default:  retire_now = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      retired <= '0;
    end else if (retire_now && (retired != {CNT_W{1'b1}})) begin
      retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_ONE;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_ALU;
        end
      end
      S_EXEC: begin
        if (is_alu_class(opc)) begin
          ctrl.alu_src_a = SRC_A_ACC1;
          ctrl.alu_src_b = (opc == OP_ADDI) ? SRC_B_IMM1 : SRC_B_ACC2;
          ctrl.alu_op    = (opc == OP_SUB) ? ALU_SUB : ALU_ADD;
        end else if (is_mem_class(opc)) begin
          ctrl.alu_src_a = SRC_A_ACC1;
          ctrl.alu_src_b = SRC_B_IMM1;
          ctrl.alu_op    = ALU_ADD;
        end else if (opc == OP_BEQ) begin
          ctrl.alu_src_a = SRC_A_ACC1;
          ctrl.alu_src_b = SRC_B_ACC2;
          ctrl.alu_op    = ALU_SUB;
        end else if (opc == OP_JMP) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_JUMP;
        end
      end
      S_BRANCH: begin
        // PC already holds PC+1 from fetch, so the target is PC + imm2.
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM2;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = PC_SRC_ALU;
      end
      S_MEM: begin
        ctrl.iord      = 1'b1;
        ctrl.alu_src_a = SRC_A_ACC1;
        ctrl.alu_src_b = SRC_B_IMM1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.mem_write = (opc == OP_SW);
      end
      S_WB: begin
        ctrl.acc_write = 1'b1;
        ctrl.acc_src   = (opc == OP_LW);
      end
      S_HALTED: ctrl.halted = 1'b1;
      S_ERROR:  ctrl.error  = 1'b1;
      default:  ctrl = '0;
    endcase
  end

  assign pc_write  = ctrl.pc_write;
  assign pc_src    = ctrl.pc_src;
  assign ir_write  = ctrl.ir_write;
  assign iord      = ctrl.iord;
  assign mem_write = ctrl.mem_write;
  assign alu_op    = ctrl.alu_op;
  assign alu_src_a = ctrl.alu_src_a;
  assign alu_src_b = ctrl.alu_src_b;
  assign acc_write = ctrl.acc_write;
  assign acc_src   = ctrl.acc_src;
  assign halted    = ctrl.halted;
  assign error     = ctrl.error;

endmodule

// File: tb/tb_dap_control_unit.sv
// Self-checking bench: builds per-instruction expected cycle sequences from
// the instruction rules and plays them against dap_control_unit.
module tb_dap_control_unit;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Control-word bits: {pc_write, pc_src, ir_write, iord, mem_write, alu_op,
  // alu_src_a, alu_src_b, acc_write, acc_src, halted, error}
  localparam logic [14:0] PCW     = 15'h4000;
  localparam logic [14:0] PCS_JMP = 15'h1000;
  localparam logic [14:0] IRW     = 15'h0800;
  localparam logic [14:0] IORD    = 15'h0400;
  localparam logic [14:0] MW      = 15'h0200;
  localparam logic [14:0] AOP     = 15'h0100;
  localparam logic [14:0] SA_ACC  = 15'h0040;
  localparam logic [14:0] SB_ONE  = 15'h0010;
  localparam logic [14:0] SB_IMM1 = 15'h0020;
  localparam logic [14:0] SB_IMM2 = 15'h0030;
  localparam logic [14:0] ACCW    = 15'h0008;
  localparam logic [14:0] ACCS    = 15'h0004;
  localparam logic [14:0] HLT     = 15'h0002;
  localparam logic [14:0] ERR     = 15'h0001;
  localparam logic [14:0] NONE    = 15'h0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, iord, mem_write, alu_op;
  logic        acc_write, acc_src, halted, error;
  logic [1:0]  pc_src, alu_src_a, alu_src_b;
  logic [15:0] retired;
  logic [14:0] obs;

  dap_control_unit #(.OPC_W(4), .TIMEOUT(15), .CNT_W(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .run       (run),
    .opcode    (opcode),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .iord      (iord),
    .mem_write (mem_write),
    .alu_op    (alu_op),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .acc_write (acc_write),
    .acc_src   (acc_src),
    .halted    (halted),
    .error     (error),
    .retired   (retired)
  );

  assign obs = {pc_write, pc_src, ir_write, iord, mem_write, alu_op,
                alu_src_a, alu_src_b, acc_write, acc_src, halted, error};

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic        run;
    logic        rdy;
    logic        zero;
    logic [3:0]  opc;
    logic [14:0] exp;
    bit          ret;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_retired = 0;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] junk();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic push(input string tag, input logic r, input logic rdy, input logic z,
                      input logic [3:0] opc, input logic [14:0] e, input bit ret);
    cyc_t c;
    c.tag = tag; c.run = r; c.rdy = rdy; c.zero = z; c.opc = opc; c.exp = e; c.ret = ret;
    q.push_back(c);
  endtask

  // Drive each queued cycle, compare mid-cycle, then advance one clock.
  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      run = c.run; mem_ready = c.rdy; alu_zero = c.zero; opcode = c.opc;
      @(negedge CLK);
      check(c.tag, 32'(obs), 32'(c.exp));
      check({c.tag, "_retired"}, 32'(retired), 32'(model_retired));
      @(posedge CLK); #1;
      if (c.ret) model_retired++;
    end
  endtask

  // IR is only loaded at the end of fetch, so opcode is noise during fetch.
  task automatic gen_fetch(input int d);
    for (int i = 0; i < d; i++) push("fetch_wait", rb(), 1'b0, rb(), junk(), SB_ONE, 1'b0);
    push("fetch_done", rb(), 1'b1, rb(), junk(), PCW | IRW | SB_ONE, 1'b0);
  endtask

  task automatic gen_instr(input logic [3:0] op, input int df, input int dm, input logic z);
    logic [14:0] mem_ctl;
    gen_fetch(df);
    push("decode", rb(), rb(), rb(), op, NONE, 1'b0);
    case (op)
      OP_ADD:  begin push("exec_add",  rb(), rb(), rb(), op, SA_ACC, 1'b0);
                     push("wb_alu", rb(), rb(), rb(), op, ACCW, 1'b1); end
      OP_SUB:  begin push("exec_sub",  rb(), rb(), rb(), op, SA_ACC | AOP, 1'b0);
                     push("wb_alu", rb(), rb(), rb(), op, ACCW, 1'b1); end
      OP_ADDI: begin push("exec_addi", rb(), rb(), rb(), op, SA_ACC | SB_IMM1, 1'b0);
                     push("wb_alu", rb(), rb(), rb(), op, ACCW, 1'b1); end
      OP_LW, OP_SW: begin
        mem_ctl = IORD | SA_ACC | SB_IMM1 | ((op == OP_SW) ? MW : NONE);
        push("exec_mem", rb(), rb(), rb(), op, SA_ACC | SB_IMM1, 1'b0);
        for (int i = 0; i < dm; i++) push("mem_wait", rb(), 1'b0, rb(), op, mem_ctl, 1'b0);
        push("mem_done", rb(), 1'b1, rb(), op, mem_ctl, op == OP_SW);
        if (op == OP_LW) push("wb_lw", rb(), rb(), rb(), op, ACCW | ACCS, 1'b1);
      end
      OP_BEQ: begin
        push("exec_beq", rb(), rb(), z, op, SA_ACC | AOP, !z);
        if (z) push("branch", rb(), rb(), rb(), op, PCW | SB_IMM2, 1'b1);
      end
      OP_JMP:  push("exec_jmp", rb(), rb(), rb(), op, PCW | PCS_JMP, 1'b1);
      default: ;
    endcase
  endtask

  task automatic do_reset();
    RST = 1'b0;
    model_retired = 0;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    logic [3:0] legal_ops [7];
    legal_ops = '{OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP};

    #1 RST = 1'b0;
    #2;
    check("reset_outputs", 32'(obs), 32'(NONE));
    check("reset_retired", 32'(retired), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;

    // IDLE ignores everything but run
    for (int i = 0; i < 3; i++) push("idle", 1'b0, rb(), rb(), junk(), NONE, 1'b0);
    push("idle_run", 1'b1, rb(), rb(), junk(), NONE, 1'b0);
    play();

    // Directed instructions
    gen_instr(OP_ADD, 0, 0, 1'b0);
    gen_instr(OP_LW, 0, 3, 1'b0);
    gen_instr(OP_BEQ, 1, 0, 1'b1);
    gen_instr(OP_BEQ, 0, 0, 1'b0);
    gen_instr(OP_SW, 2, 2, 1'b0);
    gen_instr(OP_LW, 15, 15, 1'b0);
    play();

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      gen_instr(legal_ops[$urandom_range(0, 6)],
                ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4)),
                ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4)),
                rb());
      play();
    end

    // Illegal opcode: sticky error, run ignored, retired frozen
    gen_fetch(0);
    push("decode_illegal", rb(), rb(), rb(), 4'd9, NONE, 1'b0);
    for (int i = 0; i < 5; i++) push("error_hold", 1'b1, rb(), rb(), 4'd9, ERR, 1'b0);
    play();

    // Fetch timeout: 16 unready fetch cycles then ERROR
    do_reset();
    push("idle_run", 1'b1, rb(), rb(), junk(), NONE, 1'b0);
    for (int i = 0; i < 16; i++) push("fetch_wait", rb(), 1'b0, rb(), junk(), SB_ONE, 1'b0);
    for (int i = 0; i < 3; i++) push("error_timeout", rb(), rb(), rb(), junk(), ERR, 1'b0);
    play();

    // Ready on the 16th fetch cycle still completes
    do_reset();
    push("idle_run", 1'b1, rb(), rb(), junk(), NONE, 1'b0);
    gen_instr(OP_ADD, 15, 0, 1'b0);
    gen_instr(OP_JMP, 0, 0, 1'b0);
    play();

    // Reset while SW is waiting in MEM
    gen_fetch(0);
    push("decode", rb(), rb(), rb(), OP_SW, NONE, 1'b0);
    push("exec_mem", rb(), rb(), rb(), OP_SW, SA_ACC | SB_IMM1, 1'b0);
    push("mem_wait", rb(), 1'b0, rb(), OP_SW, IORD | MW | SA_ACC | SB_IMM1, 1'b0);
    push("mem_wait", rb(), 1'b0, rb(), OP_SW, IORD | MW | SA_ACC | SB_IMM1, 1'b0);
    play();
    mem_ready = 1'b0; opcode = OP_SW; run = 1'b0;
    #1;
    check("sw_before_reset_mem_write", 32'(mem_write), 32'd1);
    RST = 1'b0;
    model_retired = 0;
    #1;
    check("sw_reset_mem_write", 32'(mem_write), 32'd0);
    check("sw_reset_outputs", 32'(obs), 32'(NONE));
    check("sw_reset_retired", 32'(retired), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;

    // HALT after reset: sticky halted, run ignored, not counted
    push("idle_run", 1'b1, rb(), rb(), junk(), NONE, 1'b0);
    gen_instr(OP_ADDI, 0, 0, 1'b0);
    gen_fetch(1);
    push("decode_halt", rb(), rb(), rb(), OP_HALT, NONE, 1'b0);
    for (int i = 0; i < 5; i++) push("halted_hold", rb(), rb(), rb(), OP_HALT, HLT, 1'b0);
    play();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
